// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: 640x480@60 Hz raster timing constants and framebuffer geometry.
package rvc_asap_pkg;
    typedef logic [9:0] cnt_t;
    localparam cnt_t H_VISIBLE = 10'd640;
    localparam cnt_t H_FP = 10'd16;
    localparam cnt_t H_SYNC = 10'd96;
    localparam cnt_t H_BP = 10'd48;
    localparam cnt_t H_TOTAL = 10'd800;
    localparam cnt_t V_VISIBLE = 10'd480;
    localparam cnt_t V_FP = 10'd10;
    localparam cnt_t V_SYNC = 10'd2;
    localparam cnt_t V_BP = 10'd33;
    localparam cnt_t V_TOTAL = 10'd525;
    localparam cnt_t H_LAST = H_TOTAL - 10'd1;
    localparam cnt_t V_LAST = V_TOTAL - 10'd1;
    localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam cnt_t H_SYNC_END = H_SYNC_START + H_SYNC;
    localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam cnt_t V_SYNC_END = V_SYNC_START + V_SYNC;
    localparam logic [12:0] FB_WORDS_PER_ROW = 13'd10;
endpackage

// File: rtl/rvc_asap_5pl_vga_sync_gen.sv
// rvc_asap_5pl_vga_sync_gen: h/v raster counters with raw sync and visible-area decode.
module rvc_asap_5pl_vga_sync_gen
    import rvc_asap_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic visible,
    output logic h_sync_raw,
    output logic v_sync_raw
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
            if (h_cnt == H_LAST)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
    end
    assign visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);
    assign h_sync_raw = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    assign v_sync_raw = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
endmodule

// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// rvc_asap_5pl_vga_ctrl: 320x240 1bpp framebuffer reader, 2x2 pixel doubling to 640x480 VGA.
module rvc_asap_5pl_vga_ctrl
    import rvc_asap_pkg::*;
#(
    parameter logic [12:0] FB_BASE = 13'd0,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        Clock,
    input  logic        Rst,
    output logic [12:0] address_b,
    input  logic [31:0] q_b,
    output logic        h_sync,
    output logic        v_sync,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        frame_start
);
    localparam cnt_t H_FETCH0 = H_TOTAL - 10'd3;
    cnt_t h_cnt, v_cnt;
    logic visible, h_sync_raw, v_sync_raw;
    logic [12:0] row_base, next_base;
    logic [31:0] pix;
    logic last_col, fetch, capture;
    logic [11:0] color;
    rvc_asap_5pl_vga_sync_gen u_sync (
        .clk(Clock),
        .rst(Rst),
        .h_cnt(h_cnt),
        .v_cnt(v_cnt),
        .visible(visible),
        .h_sync_raw(h_sync_raw),
        .v_sync_raw(v_sync_raw)
    );
    // Each 64-column word is addressed 2 cycles ahead and captured 1 cycle ahead of its first column.
    always_comb begin
        last_col = h_cnt == H_LAST;
        next_base = (v_cnt == V_LAST) ? FB_BASE : v_cnt[0] ? row_base + FB_WORDS_PER_ROW : row_base;
        fetch = (h_cnt[5:0] == 6'd61) && (h_cnt < 10'd576);
        capture = ((h_cnt[5:0] == 6'd63) && (h_cnt < 10'd576)) || last_col;
        color = !visible ? 12'h000 : pix[h_cnt[5:1]] ? FG_COLOR : BG_COLOR;
    end
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            address_b <= FB_BASE;
            row_base <= FB_BASE;
            pix <= '0;
            h_sync <= 1'b1;
            v_sync <= 1'b1;
            {red, green, blue} <= '0;
            frame_start <= 1'b0;
        end else begin
            if (h_cnt == H_FETCH0)
                address_b <= next_base;
            else if (fetch)
                address_b <= row_base + {9'd0, h_cnt[9:6]} + 13'd1;
            if (last_col)
                row_base <= next_base;
            if (capture)
                pix <= q_b;
            {red, green, blue} <= color;
            h_sync <= h_sync_raw;
            v_sync <= v_sync_raw;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end
endmodule

// File: tb/tb_rvc_asap_5pl_vga_ctrl.sv
// tb_rvc_asap_5pl_vga_ctrl: two controller instances (base 0 and wrapping base 8000) against a raster reference model.
module tb_rvc_asap_5pl_vga_ctrl;
    logic clk, rst;
    logic [12:0] a_addr, b_addr;
    logic [31:0] a_q, b_q;
    logic a_hs, a_vs, a_fs, b_hs, b_vs, b_fs;
    logic [3:0] a_red, a_green, a_blue, b_red, b_green, b_blue;
    logic [31:0] mem [8192];
    int checks = 0, errors = 0, cur_n = 0;

    typedef struct {
        int n;
        int kind;
        int dut;
        int val;
    } vec_t;
    vec_t tbl[$];

    rvc_asap_5pl_vga_ctrl dut_a (
        .Clock(clk), .Rst(rst), .address_b(a_addr), .q_b(a_q),
        .h_sync(a_hs), .v_sync(a_vs), .red(a_red), .green(a_green), .blue(a_blue),
        .frame_start(a_fs)
    );
    rvc_asap_5pl_vga_ctrl #(.FB_BASE(13'd8000), .FG_COLOR(12'h5A3), .BG_COLOR(12'h1C2)) dut_b (
        .Clock(clk), .Rst(rst), .address_b(b_addr), .q_b(b_q),
        .h_sync(b_hs), .v_sync(b_vs), .red(b_red), .green(b_green), .blue(b_blue),
        .frame_start(b_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        a_q <= mem[a_addr];
        b_q <= mem[b_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d actual=%h required=%h", nm, cur_n, act, exp);
        end
    endtask

    // Outputs at sample n reflect raster position n-1; line 0 of a run lost its word-0 fetch.
    function automatic logic [14:0] exp_out(input int n, input int base, input logic [11:0] fg, input logic [11:0] bg);
        int p, h, v;
        logic [31:0] w;
        logic px;
        logic [11:0] rgb;
        if (n == 0) return {12'h000, 3'b110};
        p = n - 1;
        h = p % 800;
        v = (p / 800) % 525;
        w = mem[(base + 10 * (v / 2) + h / 64) % 8192];
        px = (p < 64) ? 1'b0 : w[(h / 2) % 32];
        rgb = (h < 640 && v < 480) ? (px ? fg : bg) : 12'h000;
        return {rgb, !(h >= 656 && h <= 751), !(v >= 490 && v <= 491), (h == 0 && v == 0)};
    endfunction

    task automatic chk_addr(input int n, input int base, input logic [12:0] act, input string nm);
        int h, ln;
        h = n % 800;
        ln = n / 800;
        if (h % 64 == 62 && h <= 574)
            chk(nm, act, (base + 10 * ((ln % 525) / 2) + (h + 2) / 64) % 8192);
        else if (h == 798)
            chk(nm, act, (base + 10 * (((ln + 1) % 525) / 2)) % 8192);
        else if (n == 0)
            chk(nm, act, base);
    endtask

    function automatic int actual(input int kind, input int d);
        case (kind)
            0: return d ? int'(b_addr) : int'(a_addr);
            1: return d ? int'({b_red, b_green, b_blue}) : int'({a_red, a_green, a_blue});
            2: return d ? int'(b_hs) : int'(a_hs);
            default: return d ? int'(b_fs) : int'(a_fs);
        endcase
    endfunction

    task automatic run(input int count, input bit use_tbl);
        for (int n = 0; n < count; n++) begin
            @(negedge clk);
            cur_n = n;
            chk("out_a", {a_red, a_green, a_blue, a_hs, a_vs, a_fs}, exp_out(n, 0, 12'hFFF, 12'h000));
            chk("out_b", {b_red, b_green, b_blue, b_hs, b_vs, b_fs}, exp_out(n, 8000, 12'h5A3, 12'h1C2));
            chk_addr(n, 0, a_addr, "addr_a");
            chk_addr(n, 8000, b_addr, "addr_b");
            if (use_tbl)
                foreach (tbl[i])
                    if (tbl[i].n == n)
                        chk($sformatf("tbl%0d", i), actual(tbl[i].kind, tbl[i].dut), tbl[i].val);
        end
    endtask

    task automatic assert_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_a", {a_addr, a_red, a_green, a_blue, a_hs, a_vs, a_fs}, {13'd0, 12'h000, 3'b110});
        chk("async_rst_b", {b_addr, b_red, b_green, b_blue, b_hs, b_vs, b_fs}, {13'd8000, 12'h000, 3'b110});
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        // kind: 0 address, 1 rgb, 2 h_sync, 3 frame_start; dut 0 = base 0, 1 = base 8000
        tbl = '{
            '{0, 0, 0, 0}, '{0, 0, 1, 8000}, '{61, 0, 0, 0}, '{62, 0, 0, 1}, '{62, 0, 1, 8001},
            '{574, 0, 0, 9}, '{574, 0, 1, 8009}, '{798, 0, 0, 0}, '{798, 0, 1, 8000},
            '{1598, 0, 0, 10}, '{1598, 0, 1, 8010}, '{36926, 0, 0, 232}, '{36926, 0, 1, 40},
            '{38398, 0, 0, 240}, '{38398, 0, 1, 48},
            '{0, 1, 0, 0}, '{1, 1, 0, 0}, '{1, 1, 1, 'h1C2}, '{640, 1, 0, 'hFFF}, '{640, 1, 1, 'h5A3},
            '{641, 1, 0, 0}, '{801, 1, 0, 'hFFF}, '{802, 1, 0, 'hFFF}, '{803, 1, 0, 0},
            '{801, 1, 1, 'h5A3}, '{803, 1, 1, 'h1C2}, '{1662, 1, 0, 0}, '{1663, 1, 0, 'hFFF},
            '{1664, 1, 0, 'hFFF}, '{2463, 1, 0, 'hFFF}, '{1663, 1, 1, 'h5A3},
            '{656, 2, 0, 1}, '{657, 2, 0, 0}, '{752, 2, 0, 0}, '{753, 2, 0, 1},
            '{0, 3, 0, 0}, '{1, 3, 0, 1}, '{2, 3, 0, 0}, '{1, 3, 1, 1}
        };
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0001;
        mem[9] = 32'h8000_0000;
        mem[10] = 32'h8000_0000;
        mem[8000] = 32'h0000_0001;
        mem[8009] = 32'h8000_0000;
        mem[8010] = 32'h8000_0000;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        run(38410, 1'b1);
        assert_rst();
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        #2 rst = 1'b0;
        run(4300, 1'b0);
        assert_rst();
        #2 rst = 1'b0;
        run(2400, 1'b0);
        assert_rst();
        for (int i = 0; i < 8192; i++) mem[i] = 32'hFFFF_FFFF;
        #2 rst = 1'b0;
        run(9600, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rvc_asap_5pl_vga_ctrl.md
# rvc_asap_5pl_vga_ctrl

VGA display controller; the reader side of the VGA memory's dedicated read port. Generates 640x480@60 Hz raster timing and fetches a 320x240 1-bit-per-pixel framebuffer word-by-word over the VGA memory's synchronous read port (`address_b`/`q_b`, one-cycle latency). It doubles each framebuffer pixel 2x2 and drives 4-bit RGB plus active-low syncs to the board DAC.

## Interface
Parameters:
- `FB_BASE`, default 13'd0: word offset of framebuffer pixel (0,0) in VGA memory.
- `FG_COLOR`, default 12'hFFF: {R,G,B} driven for a set bit.
- `BG_COLOR`, default 12'h000: {R,G,B} driven for a clear bit during the visible area.

Ports (one clock; reset asynchronous, active-high):
- `Clock` in 1: pixel clock, 25 MHz nominal.
- `Rst` in 1: asynchronous, active-high reset.
- `address_b` out 13: registered word address to VGA memory read port.
- `q_b` in 32: VGA memory read data, valid the cycle after `address_b` is presented.
- `h_sync` out 1: registered, active-low.
- `v_sync` out 1: registered, active-low.
- `red`, `green`, `blue` out 4 each: registered; 0 outside the visible area.
- `frame_start` out 1: registered one-cycle pulse at screen pixel (0,0).

## Operation
- Horizontal counter `h_cnt` runs 0..799: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter `v_cnt` runs 0..524, advancing when `h_cnt` wraps 799->0: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Sync rules: `h_sync`=0 iff h_cnt in 656..751; `v_sync`=0 iff v_cnt in 490..491.
- Framebuffer layout:
  - Row r (0..239) = 10 words at FB_BASE + 10*r.
  - Word k covers fb columns 32k..32k+31.
  - Bit 0 is the leftmost pixel.
  - Screen (x,y) shows fb pixel (x>>1, y>>1).
  - Total footprint 2400 words; address arithmetic is 13-bit and wraps modulo 8192.
- Row base tracking: a base register adds 10 after every odd line. No multiplier.
- Fetch schedule:
  - Word k (0..9) of the line that is about to display is presented on `address_b` during cycle h_cnt = 64k-2 (mod 800).
  - Word 0 is therefore fetched during h_cnt=798 of the preceding line, using the next line's row (v=524 -> next row is 0).
  - `q_b` is captured into a 32-bit pixel register at the end of cycle 64k-1.
  - During h_cnt 64k..64k+63 the pixel bit selected is h_cnt[5:1].
- Fetches continue during blanking lines. The data is don't-care and the RGB outputs are forced to 0.
- Pixel output: the selected bit chooses FG_COLOR or BG_COLOR when h_cnt<640 and v_cnt<480, and 0 otherwise.

## Timing
- All outputs are registered from counter state, with a one-cycle pipeline.
  - Screen column x appears on RGB during cycle h_cnt = x+1.
  - `h_sync`, `v_sync` and `frame_start` carry the same one-cycle delay, so they stay aligned with RGB.
- `frame_start`=1 during the cycle after h_cnt=0, v_cnt=0.
- Reset values:
  - h_cnt=0, v_cnt=0.
  - `h_sync`=1, `v_sync`=1.
  - RGB=0, `frame_start`=0.
  - `address_b`=FB_BASE, pixel register=0.
- After reset deassertion the controller starts at the visible (0,0).
  - The first-line word 0 fetch was missed, so line 0 of frame 0 shows pixel-register contents (0 -> BG_COLOR) for columns 0..63.
  - All later lines are correct.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). No partial line completes.
- Line period 800 cycles; frame period 420000 cycles.
- Memory read latency is exactly 1 cycle. The controller never depends on `q_b` outside the capture cycle.

## Structure
- Timing constants belong in `rvc_asap_pkg`: H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525, FB_WORDS_PER_ROW=10.
- One sub-module: `rvc_asap_5pl_vga_sync_gen`.
  - Contains the h/v counters and the raw sync/visible decode.
  - Exports h_cnt, v_cnt, a visible flag and the raw syncs.
- The top level holds the fetch addressing, pixel register, color mux and output registers.

## Test plan
- Reset then run 2 frames: h_sync low for exactly 96 cycles every 800 cycles; v_sync low for exactly 1600 cycles every 420000; `frame_start` one pulse per 420000 cycles.
- Memory model with word FB_BASE+0 = 32'h0000_0001: line 0 of frame 1 has RGB=FG_COLOR only for screen columns 0..1; line 1 identical; line 2 (row 1) follows word FB_BASE+10.
- Address trace: for one line, `address_b` during h_cnt=62, 126, ..., 574 equals base+1..base+9, and during h_cnt=798 equals next row's base; after v=524 it returns to FB_BASE.
- All words 32'hFFFF_FFFF: RGB=FG_COLOR for every visible pixel; RGB=0 for every cycle with h_cnt>=641 or in vertical blanking, checked with the one-cycle output offset.
- FB_BASE=13'd8000: row 23 word 2 address = (8000+232) mod 8192 = 40, checking wrap-around.
- Assert Rst at h_cnt=300, v_cnt=200 for 3 cycles: outputs take reset values asynchronously; after release the first `frame_start` arrives 1 cycle later and timing is correct thereafter.
